// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter
// Round-robin front end that shares one pipelined 32x32 multiplier among
// N_REQ requesters. Accepts at most one operand pair per cycle, tracks the
// owner of every in-flight product in a tag pipeline matched to the
// multiplier latency, and steers each 64-bit product back to its owner.
// The multiplier's valid_out is cross-checked against the tag pipeline and
// any disagreement raises a sticky error.

module vedic_mul_arbiter #(
   parameter int N_REQ       = 4,
   parameter int MUL_LATENCY = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             arb_en,
   input  logic [N_REQ-1:0]                 req_valid,
   input  logic [32*N_REQ-1:0]              req_a,
   input  logic [32*N_REQ-1:0]              req_b,
   output logic [N_REQ-1:0]                 req_ready,
   output logic [31:0]                      mul_a,
   output logic [31:0]                      mul_b,
   output logic                             mul_issue,
   input  logic [63:0]                      mul_result,
   input  logic                             mul_valid_out,
   output logic [N_REQ-1:0]                 rsp_valid,
   output logic [63:0]                      rsp_data,
   output logic [$clog2(MUL_LATENCY+3)-1:0] inflight,
   output logic                             err
);

   // Index width for requester ids and the priority pointer.
   localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   // One extra bit so pointer + offset can exceed N_REQ-1 before wrapping.
   localparam int SW  = PW + 1;
   localparam int IFW = $clog2(MUL_LATENCY + 3);
   localparam int GW  = $clog2(MUL_LATENCY + 2);
   // Tag stages: one for the issue register plus one per multiplier stage.
   localparam int NST = MUL_LATENCY + 1;

   // Expand a requester id into a one-hot vector.
   function automatic logic [N_REQ-1:0] onehot_f(input logic [PW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Operand views per requester.
   logic [31:0]      op_a_s [N_REQ];
   logic [31:0]      op_b_s [N_REQ];

   // Arbitration.
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gidx_s;
   logic             found_s;
   logic             accept_s;
   logic [SW-1:0]    sum_s;
   logic [PW-1:0]    cand_s;

   // Issue registers.
   logic [31:0]      mul_a_q, mul_a_d;
   logic [31:0]      mul_b_q, mul_b_d;
   logic             mul_issue_q, mul_issue_d;

   // Tag pipeline.
   logic             tag_v_q  [NST];
   logic [PW-1:0]    tag_id_q [NST];
   logic             tail_v_s;
   logic [PW-1:0]    tail_id_s;

   // Response, occupancy and protocol check state.
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [63:0]      rsp_data_q, rsp_data_d;
   logic [IFW-1:0]   inflight_q, inflight_d;
   logic [GW-1:0]    guard_q, guard_d;
   logic             err_q, err_d;

   assign tail_v_s  = tag_v_q[MUL_LATENCY];
   assign tail_id_s = tag_id_q[MUL_LATENCY];

   // Slice the packed operand buses into one word per requester.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         op_a_s[i] = req_a[32*i +: 32];
         op_b_s[i] = req_b[32*i +: 32];
      end
   end

   // Search for the first valid requester starting at the priority pointer.
   always_comb begin
      gidx_s  = '0;
      found_s = 1'b0;
      sum_s   = '0;
      cand_s  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s   = {1'b0, ptr_q} + SW'(k);
         sum_s   = (sum_s >= SW'(N_REQ)) ? (sum_s - SW'(N_REQ)) : sum_s;
         cand_s  = sum_s[PW-1:0];
         gidx_s  = (!found_s && req_valid[cand_s]) ? cand_s : gidx_s;
         found_s = found_s | req_valid[cand_s];
      end
   end

   // A transfer needs reset released, arbitration enabled and a valid request.
   assign accept_s = rst & arb_en & found_s;

   // One-hot grant; low whenever no transfer can happen this cycle.
   always_comb begin
      if (accept_s) begin
         req_ready = onehot_f(gidx_s);
      end else begin
         req_ready = '0;
      end
   end

   // Move priority past the winner so it becomes lowest next time.
   always_comb begin
      if (!accept_s) begin
         ptr_d = ptr_q;
      end else if (gidx_s == PW'(N_REQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = gidx_s + PW'(1);
      end
   end

   // Capture the winner's operands; hold the last operands when idle.
   always_comb begin
      if (accept_s) begin
         mul_a_d     = op_a_s[gidx_s];
         mul_b_d     = op_b_s[gidx_s];
         mul_issue_d = 1'b1;
      end else begin
         mul_a_d     = mul_a_q;
         mul_b_d     = mul_b_q;
         mul_issue_d = 1'b0;
      end
   end

   // Return the product to its owner when a tagged operation leaves the pipe.
   always_comb begin
      if (tail_v_s) begin
         rsp_valid_d = onehot_f(tail_id_s);
         rsp_data_d  = mul_result;
      end else begin
         rsp_valid_d = '0;
         rsp_data_d  = rsp_data_q;
      end
   end

   // Occupancy: accept adds one, response removes one, both cancel.
   always_comb begin
      case ({accept_s, tail_v_s})
         2'b10:   inflight_d = inflight_q + IFW'(1);
         2'b01:   inflight_d = inflight_q - IFW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Guard window ignores multiplier outputs left over from before reset.
   always_comb begin
      if (guard_q != '0) begin
         guard_d = guard_q - GW'(1);
      end else begin
         guard_d = guard_q;
      end
   end

   // Sticky flag for a multiplier valid that disagrees with the tag pipeline.
   always_comb begin
      if ((guard_q == '0) && (tail_v_s != mul_valid_out)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Pointer, issue, response, occupancy and error registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q       <= '0;
         mul_a_q     <= 32'd0;
         mul_b_q     <= 32'd0;
         mul_issue_q <= 1'b0;
         rsp_valid_q <= '0;
         rsp_data_q  <= 64'd0;
         inflight_q  <= '0;
         guard_q     <= GW'(MUL_LATENCY + 1);
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_issue_q <= mul_issue_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         inflight_q  <= inflight_d;
         guard_q     <= guard_d;
         err_q       <= err_d;
      end
   end

   // Shift requester tags alongside the multiplier stages.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NST; s++) begin
            tag_v_q[s]  <= 1'b0;
            tag_id_q[s] <= '0;
         end
      end else begin
         tag_v_q[0]  <= accept_s;
         tag_id_q[0] <= gidx_s;
         for (int s = 1; s < NST; s++) begin
            tag_v_q[s]  <= tag_v_q[s-1];
            tag_id_q[s] <= tag_id_q[s-1];
         end
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_issue = mul_issue_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign inflight  = inflight_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Self-checking bench for vedic_mul_arbiter: a pipelined multiplier model
// drives the product inputs, and a queue-based reference predicts grants,
// issue registers, responses, occupancy and the error flag every cycle.

module tb_vedic_mul_arbiter;
   localparam int N  = 4;
   localparam int L  = 4;
   localparam int IW = $clog2(L + 3);

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            arb_en = 1'b0;
   logic            force_v = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_a = '0;
   logic [32*N-1:0] req_b = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     mul_a, mul_b;
   logic            mul_issue, mul_valid_out, err;
   logic [63:0]     mul_result, rsp_data;
   logic [IW-1:0]   inflight;

   always #5 clk = ~clk;

   vedic_mul_arbiter #(.N_REQ(N), .MUL_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .arb_en(arb_en),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
      .mul_issue(mul_issue), .mul_result(mul_result),
      .mul_valid_out(mul_valid_out), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .inflight(inflight), .err(err)
   );

   // Pipelined multiplier environment (not reset, like a real datapath).
   logic [63:0] mp_d [L];
   logic        mp_v [L];
   initial for (int i = 0; i < L; i++) begin mp_v[i] = 1'b0; mp_d[i] = 64'd0; end
   always @(posedge clk) begin
      mp_v[0] <= mul_issue;
      mp_d[0] <= {32'd0, mul_a} * {32'd0, mul_b};
      for (int i = 1; i < L; i++) begin
         mp_v[i] <= mp_v[i-1];
         mp_d[i] <= mp_d[i-1];
      end
   end
   assign mul_result    = mp_d[L-1];
   assign mul_valid_out = mp_v[L-1] | force_v;

   // Reference model state.
   typedef struct { int due; int id; logic [63:0] p; } pend_t;
   pend_t        pq[$];
   int           glog[$];
   int           checks = 0, errors = 0;
   int           ecount = 0, rst_edge = 0, m_ptr = 0, rsp_seen = 0;
   logic         m_issue = 1'b0, m_err = 1'b0;
   logic [31:0]  m_a = 32'd0, m_b = 32'd0;
   logic [N-1:0] m_rv = '0;
   logic [63:0]  m_rd = 64'd0;
   logic [N-1:0] last_ready = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d actual=%0h required=%0h", name, ecount, act, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v, input int p, input logic en, input logic r);
      if (!r || !en) return -1;
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // One clock: check the grant, take the edge, update model, check outputs.
   task automatic step();
      int           g;
      logic [N-1:0] exp_ready;
      logic [31:0]  ga, gb;
      logic         due;
      pend_t        e;
      #2;
      g = model_grant(req_valid, m_ptr, arb_en, rst);
      exp_ready = '0;
      ga = 32'd0; gb = 32'd0;
      if (g >= 0) begin
         exp_ready[g] = 1'b1;
         ga = req_a[32*g +: 32];
         gb = req_b[32*g +: 32];
         glog.push_back(g);
      end
      last_ready = req_ready;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      @(posedge clk);
      ecount++;
      if (!rst) begin
         pq.delete();
         m_ptr = 0; m_issue = 1'b0; m_a = 32'd0; m_b = 32'd0;
         m_rv = '0; m_rd = 64'd0; m_err = 1'b0; rst_edge = ecount;
      end else begin
         due = (pq.size() > 0) && (pq[0].due == ecount);
         if ((ecount - rst_edge) >= L + 2 && force_v && !due) m_err = 1'b1;
         m_rv = '0;
         if (due) begin
            m_rv[pq[0].id] = 1'b1;
            m_rd = pq[0].p;
            void'(pq.pop_front());
         end
         m_issue = (g >= 0);
         if (g >= 0) begin
            m_a = ga; m_b = gb;
            e.due = ecount + L + 1; e.id = g; e.p = {32'd0, ga} * {32'd0, gb};
            pq.push_back(e);
            m_ptr = (g + 1) % N;
         end
      end
      #1;
      check("mul_issue", 64'(mul_issue), 64'(m_issue));
      check("mul_a", 64'(mul_a), 64'(m_a));
      check("mul_b", 64'(mul_b), 64'(m_b));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
      check("rsp_data", rsp_data, m_rd);
      check("inflight", 64'(inflight), 64'(pq.size()));
      check("err", 64'(err), 64'(m_err));
      if (|rsp_valid) rsp_seen++;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = $urandom;
         req_b[32*i +: 32] = $urandom;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      req_valid = '0;
      repeat (L + 3) step();
   endtask

   initial begin
      // Reset with requests pending: no grant may appear.
      rst = 1'b0; arb_en = 1'b1; req_valid = 4'b1111;
      repeat (3) step();
      check("rst_ready_low", 64'(last_ready), 64'd0);
      rst = 1'b1; req_valid = '0;
      repeat (L + 3) step();

      // Single request from requester 2: 7*9.
      req_a = '0; req_b = '0;
      req_a[64 +: 32] = 32'd7; req_b[64 +: 32] = 32'd9;
      req_valid = 4'b0100;
      step();
      check("t1_ready", 64'(last_ready), 64'h4);
      check("t1_issue", 64'(mul_issue), 64'd1);
      check("t1_inflight1", 64'(inflight), 64'd1);
      req_valid = '0;
      step();
      check("t1_issue_drop", 64'(mul_issue), 64'd0);
      repeat (3) step();
      check("t1_not_early", 64'(rsp_valid), 64'd0);
      step();
      check("t1_rsp_valid", 64'(rsp_valid), 64'h4);
      check("t1_rsp_data", rsp_data, 64'd63);
      check("t1_inflight0", 64'(inflight), 64'd0);

      // Round-robin fairness from a fresh pointer.
      do_reset();
      glog.delete();
      req_valid = 4'b1111;
      for (int c = 0; c < 12; c++) begin rand_ops(); step(); end
      req_valid = '0;
      check("rr_count", 64'(glog.size()), 64'd12);
      for (int k = 0; k < 12 && k < glog.size(); k++) check("rr_order", 64'(glog[k]), 64'(k % 4));
      repeat (L + 2) step();

      // Wrap and skip: pointer to 3, then only 1 and 3 valid.
      req_valid = 4'b0100; rand_ops(); step();
      glog.delete();
      req_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin rand_ops(); step(); end
      req_valid = '0;
      check("wrap_count", 64'(glog.size()), 64'd4);
      if (glog.size() == 4) begin
         check("wrap_g0", 64'(glog[0]), 64'd3);
         check("wrap_g1", 64'(glog[1]), 64'd1);
         check("wrap_g2", 64'(glog[2]), 64'd3);
         check("wrap_g3", 64'(glog[3]), 64'd1);
      end
      repeat (L + 2) step();

      // Maximum operands.
      req_a[0 +: 32] = 32'hFFFF_FFFF; req_b[0 +: 32] = 32'hFFFF_FFFF;
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      repeat (L + 1) step();
      check("max_rsp_valid", 64'(rsp_valid), 64'h1);
      check("max_rsp_data", rsp_data, 64'hFFFF_FFFE_0000_0001);

      // Drop arb_en with three operations in flight.
      req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin rand_ops(); step(); end
      arb_en = 1'b0; rsp_seen = 0;
      step();
      check("en_ready_low", 64'(last_ready), 64'd0);
      repeat (L + 2) step();
      check("en_drain_count", 64'(rsp_seen), 64'd3);
      req_valid = '0; arb_en = 1'b1;

      // Reset with three operations in flight.
      req_valid = 4'b1111;
      for (int c = 0; c < 3; c++) begin rand_ops(); step(); end
      rsp_seen = 0; rst = 1'b0;
      step();
      check("mid_rst_ready", 64'(last_ready), 64'd0);
      rst = 1'b1; req_valid = '0;
      repeat (L + 3) step();
      check("mid_rst_rsp", 64'(rsp_seen), 64'd0);
      check("mid_rst_inflight", 64'(inflight), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);

      // Randomized traffic.
      for (int c = 0; c < 300; c++) begin
         req_valid = N'($urandom);
         arb_en = ($urandom_range(0, 7) != 0);
         rand_ops();
         step();
      end
      req_valid = '0; arb_en = 1'b1;
      repeat (L + 2) step();

      // Spurious multiplier valid after the guard window.
      force_v = 1'b1;
      step();
      force_v = 1'b0;
      check("err_set", 64'(err), 64'd1);
      repeat (3) step();
      check("err_sticky", 64'(err), 64'd1);
      rst = 1'b0;
      step();
      check("err_cleared", 64'(err), 64'd0);
      rst = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout edge=%0d", ecount);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vedic_mul_arbiter.md
Name: vedic_mul_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one pipelined vedic32x32 multiplier among N_REQ requesters in the matrix multiplier datapath.
- Accepts at most one operand pair per cycle and drives it into the multiplier.
- Tracks the requester ID of every in-flight product in a tag pipeline matched to the multiplier latency, and routes each 64-bit result back to its requester.
- Cross-checks the multiplier's valid_out against its own tag pipeline and flags mismatches.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 4, cycles from the multiplier sampling a/b to result/valid_out being valid.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight products still drain.
- req_valid  in  N_REQ  per-requester request.
- req_a  in  32*N_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- mul_a  out  32  operand A to the multiplier (registered).
- mul_b  out  32  operand B to the multiplier (registered).
- mul_issue  out  1  high when mul_a/mul_b carry a new operation.
- mul_result  in  64  multiplier product.
- mul_valid_out  in  1  multiplier valid_out.
- rsp_valid  out  N_REQ  one-hot response strobe, one cycle long, no backpressure.
- rsp_data  out  64  product for the strobed requester.
- inflight  out  $clog2(MUL_LATENCY+3)  number of accepted but not yet responded operations.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst low at a posedge):
  - mul_a, mul_b, rsp_data = 0.
  - mul_issue, rsp_valid, err, inflight = 0.
  - Priority pointer = 0.
  - Tag pipeline cleared.
  - Guard counter loaded with MUL_LATENCY+1.
  - req_ready is combinationally 0 while rst is low.
- Arbitration (combinational):
  - req_ready is asserted when rst is high and arb_en is high.
  - Grant goes to the first set req_valid bit, searching from the pointer upward with wrap-around.
  - At most one bit of req_ready is high; req_ready is 0 if no requester is valid.
  - req_ready[i] never rises without req_valid[i].
- Pointer update:
  - On an accepting edge, pointer = granted index + 1, wrapping N_REQ-1 to 0.
  - Otherwise the pointer holds.
- Issue:
  - The acceptance edge E0 registers mul_a/mul_b from the granted requester and sets mul_issue = 1 for one cycle.
  - With no acceptance, mul_issue = 0 and mul_a/mul_b hold their previous values.
- Tag pipeline: MUL_LATENCY+1 stages of {valid, id}, shifted every cycle, entered at E0.
- Response:
  - At edge E0+MUL_LATENCY+1, rsp_data <= mul_result and rsp_valid <= onehot(id) if the tail tag is valid; otherwise rsp_valid <= 0 and rsp_data holds.
  - Response latency is exactly MUL_LATENCY+1 edges after acceptance, in the order products were accepted.
- Throughput: back-to-back acceptances every cycle are allowed; there are no bubbles.
- inflight:
  - Increments on acceptance and decrements on response.
  - Both on the same edge leaves it unchanged.
  - Maximum value is MUL_LATENCY+1.
- err:
  - Set when the guard counter is 0 and the tail tag valid differs from mul_valid_out.
  - Cleared only by reset.
  - The guard counter decrements to 0 after reset, masking stale multiplier outputs.
- Reset mid-operation: all in-flight products are discarded, with no rsp_valid for them and no err.
- arb_en falling: takes effect the same cycle (req_ready = 0); the pipeline keeps draining.
- Simultaneous acceptance and response in the same cycle are independent and both occur.

Test Plan:
- Single request: after reset, requester 2 sends a=7, b=9 at E0 → req_ready=4'b0100 in that cycle; mul_issue high for 1 cycle; rsp_valid=4'b0100, rsp_data=63 exactly 5 edges after E0; inflight goes 1 then 0.
- Round-robin fairness: all 4 requesters hold req_valid with random 32-bit operands for 12 cycles → grant order 0,1,2,3,0,1,2,3,…; one acceptance per cycle; every rsp_data equals a*b (64-bit) to the correct one-hot requester, in order.
- Wrap and skip: pointer at 3, only requesters 1 and 3 valid → grants 3, 1, 3, 1.
- Maximum operands: a=b=32'hFFFFFFFF → rsp_data = 64'hFFFFFFFE00000001.
- arb_en and reset mid-flight:
  - Drop arb_en with 3 ops in flight → req_ready=0 and all 3 responses still arrive.
  - Assert rst low with 3 ops in flight → no rsp_valid afterwards, inflight=0, err=0.
- Error detection: force mul_valid_out high with no tag pending, after the guard has expired → err=1 on the next edge and stays 1 until reset.
